// File: rtl/piso_bit_feeder_pkg.sv
// Shared types and helpers for the parallel-in/serial-out bit feeder.
// Holds the FSM encoding and the counter-width helper used by the feeder.
package piso_bit_feeder_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_bit_feeder.sv
// Serialises W-bit words onto a single-bit stream for the downstream pattern detector,
// with registered bit-valid and frame-boundary markers and no bubble between frames.
module piso_bit_feeder
  import piso_bit_feeder_pkg::*;
#(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         en,
  output logic         x,
  output logic         x_valid,
  output logic         frame_start,
  output logic         frame_end,
  output state_e       dbg_state_o
);

  localparam int              CW       = cnt_width(W);
  localparam logic [CW-1:0]   CNT_LAST = CW'(W - 1);

  // Handshake: a word transfers on a rising edge where in_valid && in_ready.
  // in_valid may stay high indefinitely; in_ready is a pure decode of state, cnt and en.
  state_e         state_q, state_d;
  logic [W-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           x_q, x_d;
  logic           xv_q, xv_d;
  logic           fs_q, fs_d;
  logic           fe_q, fe_d;

  logic           head_bit;
  logic [W-1:0]   shreg_shifted;
  logic           cnt_is_last;

  assign head_bit      = MSB_FIRST ? shreg_q[W-1] : shreg_q[0];
  assign shreg_shifted = MSB_FIRST ? {shreg_q[W-2:0], 1'b0} : {1'b0, shreg_q[W-1:1]};
  assign cnt_is_last   = (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    xv_d     = 1'b0;
    fs_d     = 1'b0;
    fe_d     = 1'b0;
    in_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shreg_d = in_data;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (en) begin
          x_d  = head_bit;
          xv_d = 1'b1;
          fs_d = (cnt_q == '0);
          fe_d = cnt_is_last;
          if (cnt_is_last) begin
            // Last bit leaves and the next word loads on the same edge.
            in_ready = 1'b1;
            if (in_valid) begin
              shreg_d = in_data;
              cnt_d   = '0;
            end else begin
              shreg_d = shreg_shifted;
              cnt_d   = '0;
              state_d = ST_IDLE;
            end
          end else begin
            shreg_d = shreg_shifted;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      fs_q    <= fs_d;
      fe_q    <= fe_d;
    end
  end

  assign x           = x_q;
  assign x_valid     = xv_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_piso_bit_feeder.sv
// Directed bench for piso_bit_feeder: MSB-first and LSB-first instances on one clock,
// with a simple rising-edge detector chained onto the MSB-first stream.
module tb_piso_bit_feeder;
  import piso_bit_feeder_pkg::*;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MSB-first instance
  logic [7:0] in_data;
  logic       in_valid, in_ready, en;
  logic       x, x_valid, frame_start, frame_end;
  state_e     dbg_state;

  piso_bit_feeder #(.W(8), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .en(en), .x(x), .x_valid(x_valid), .frame_start(frame_start), .frame_end(frame_end),
    .dbg_state_o(dbg_state)
  );

  // LSB-first instance
  logic [7:0] l_in_data;
  logic       l_in_valid, l_in_ready, l_en;
  logic       l_x, l_x_valid, l_frame_start, l_frame_end;
  state_e     l_dbg_state;

  piso_bit_feeder #(.W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_data(l_in_data), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .en(l_en), .x(l_x), .x_valid(l_x_valid), .frame_start(l_frame_start),
    .frame_end(l_frame_end), .dbg_state_o(l_dbg_state)
  );

  // Mealy rising-transition detector fed by the MSB-first stream
  logic det_prev_q;
  logic det_y;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) det_prev_q <= 1'b0;
    else if (x_valid) det_prev_q <= x;
  end
  assign det_y = x_valid & x & ~det_prev_q;

  // scoreboard
  int n_vec;
  int n_miss;
  logic [0:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w, input bit msb_first);
    for (int i = 0; i < 8; i++) begin
      if (msb_first) exp_q.push_back(w[7-i]);
      else           exp_q.push_back(w[i]);
    end
  endtask

  // table vectors: exp = {in_ready, x, x_valid, frame_start, frame_end}
  typedef struct {
    logic       en;
    logic       vld;
    logic [7:0] data;
    logic [4:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic e, input logic v, input logic [7:0] d,
                              input logic rdy, input logic xb, input logic xv,
                              input logic fs, input logic fe);
    vec_t r;
    r.en   = e;
    r.vld  = v;
    r.data = d;
    r.exp  = {rdy, xb, xv, fs, fe};
    return r;
  endfunction

  function automatic logic [4:0] main_outs();
    return {in_ready, x, x_valid, frame_start, frame_end};
  endfunction

  vec_t vecs[12];

  initial begin
    int acc, nxv, first_c, last_c, fe_at, fs2_at, ny;
    bit prev_en, hit;

    n_vec = 0;
    n_miss = 0;

    // single word 0xA5, en high, accepted in row 0 (cycle N)
    vecs[0]  = mk(1, 1, 8'hA5, 1, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 8'h00, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 8'h00, 0, 1, 1, 1, 0);
    vecs[3]  = mk(1, 0, 8'h00, 0, 0, 1, 0, 0);
    vecs[4]  = mk(1, 0, 8'h00, 0, 1, 1, 0, 0);
    vecs[5]  = mk(1, 0, 8'h00, 0, 0, 1, 0, 0);
    vecs[6]  = mk(1, 0, 8'h00, 0, 0, 1, 0, 0);
    vecs[7]  = mk(1, 0, 8'h00, 0, 1, 1, 0, 0);
    vecs[8]  = mk(1, 0, 8'h00, 1, 0, 1, 0, 0);
    vecs[9]  = mk(1, 0, 8'h00, 1, 1, 1, 0, 1);
    vecs[10] = mk(1, 0, 8'h00, 1, 1, 0, 0, 0);
    vecs[11] = mk(0, 0, 8'h00, 1, 1, 0, 0, 0);

    rst = 1'b1;
    in_data = '0; in_valid = 1'b0; en = 1'b0;
    l_in_data = '0; l_in_valid = 1'b0; l_en = 1'b0;

    // reset check
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset outputs", main_outs(), 5'b10000);
    check("reset state", dbg_state, ST_IDLE);
    rst = 1'b0;

    // table-driven single word
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      en = vecs[i].en;
      in_valid = vecs[i].vld;
      in_data = vecs[i].data;
      #1;
      check($sformatf("a5 row %0d", i), main_outs(), vecs[i].exp);
    end

    // back-to-back 0x01 then 0x80 with in_valid held high
    exp_q.delete();
    push_word(8'h01, 1'b1);
    push_word(8'h80, 1'b1);
    acc = 0; nxv = 0; first_c = -1; last_c = -1; fe_at = -1; fs2_at = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      en = 1'b1;
      if (acc == 0)      begin in_valid = 1'b1; in_data = 8'h01; end
      else if (acc == 1) begin in_valid = 1'b1; in_data = 8'h80; end
      else               begin in_valid = 1'b0; in_data = 8'hEE; end
      #1;
      if (x_valid) begin
        nxv++;
        if (first_c < 0) first_c = c;
        last_c = c;
        if (exp_q.size() > 0) check($sformatf("b2b bit %0d", nxv), x, exp_q.pop_front());
        else                  check("b2b extra bit", 1, 0);
        if (frame_end && fe_at < 0) fe_at = c;
        if (frame_start && c != first_c) fs2_at = c;
      end
      if (in_valid && in_ready) acc++;
    end
    check("b2b accepted", acc, 2);
    check("b2b xv count", nxv, 16);
    check("b2b contiguous", last_c - first_c + 1, 16);
    check("b2b fs after fe", fs2_at, fe_at + 1);
    check("b2b leftover", exp_q.size(), 0);

    // stall: en 1,0,0 repeating on 0xC3
    exp_q.delete();
    push_word(8'hC3, 1'b1);
    acc = 0; nxv = 0; prev_en = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      en = (c % 3 == 0);
      in_valid = (acc == 0);
      in_data = 8'hC3;
      #1;
      if (x_valid) begin
        nxv++;
        check($sformatf("stall en before xv %0d", nxv), prev_en, 1);
        if (exp_q.size() > 0) check($sformatf("stall bit %0d", nxv), x, exp_q.pop_front());
        else                  check("stall extra bit", 1, 0);
      end
      if (in_valid && in_ready) acc++;
      prev_en = en;
    end
    check("stall xv count", nxv, 8);
    in_valid = 1'b0;
    en = 1'b0;

    // LSB-first, 0x01
    exp_q.delete();
    push_word(8'h01, 1'b0);
    acc = 0; nxv = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      l_en = 1'b1;
      l_in_valid = (acc == 0);
      l_in_data = 8'h01;
      #1;
      if (l_x_valid) begin
        nxv++;
        if (exp_q.size() > 0) check($sformatf("lsb bit %0d", nxv), l_x, exp_q.pop_front());
        else                  check("lsb extra bit", 1, 0);
      end
      if (l_in_valid && l_in_ready) acc++;
    end
    check("lsb xv count", nxv, 8);
    l_in_valid = 1'b0;

    // reset after 3 bits of 0xFF
    acc = 0; nxv = 0; hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      en = 1'b1;
      in_valid = (acc == 0);
      in_data = 8'hFF;
      #1;
      if (x_valid) nxv++;
      if (in_valid && in_ready) acc++;
      if (nxv == 3) begin
        hit = 1'b1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst outputs", main_outs(), 5'b10000);
      end
    end
    check("midrst reached 3 bits", hit, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    nxv = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      if (x_valid) nxv++;
    end
    check("midrst no replay", nxv, 0);

    // chained detector on 0x55
    exp_q.delete();
    push_word(8'h55, 1'b1);
    acc = 0; nxv = 0; ny = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      en = 1'b1;
      in_valid = (acc == 0);
      in_data = 8'h55;
      #1;
      if (x_valid) begin
        nxv++;
        if (exp_q.size() > 0) check($sformatf("det bit %0d", nxv), x, exp_q.pop_front());
        else                  check("det extra bit", 1, 0);
      end
      if (det_y) ny++;
      if (in_valid && in_ready) acc++;
    end
    in_valid = 1'b0;
    check("det xv count", nxv, 8);
    check("det y pulses", ny, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/piso_bit_feeder.md
Name: piso_bit_feeder

Overview:
- Parallel-in/serial-out feeder that drives the single-bit input stream of the Mealy pattern-detector stage.
- Accepts W-bit words over a valid/ready handshake and emits them one bit per enabled cycle.
- Provides bit-valid and frame-boundary markers so the downstream detector and counters can gate on them.
- Supports back-to-back words with no bubble between frames.

Parameters:
- W, 8, word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 = shift out bit W-1 first; 0 = bit 0 first.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_data  input  W  parallel word to serialise
- in_valid  input  1  in_data is valid
- in_ready  output  1  feeder can accept a word this cycle
- en  input  1  bit strobe; one bit is emitted per cycle with en=1
- x  output  1  serial bit to the detector (registered)
- x_valid  output  1  x carries a new bit this cycle (registered)
- frame_start  output  1  x is the first bit of a word (registered)
- frame_end  output  1  x is the last bit of a word (registered)

Behaviour:
- State: FSM {IDLE, SHIFT}, shift register shreg[W-1:0], bit counter cnt[$clog2(W)-1:0].
- Asynchronous reset:
  - State = IDLE; shreg = 0; cnt = 0.
  - x = 0, x_valid = 0, frame_start = 0, frame_end = 0.
  - in_ready = 1, because it is a combinational decode of IDLE.
- in_ready is combinational: 1 in IDLE; 1 in SHIFT when en=1 and cnt==W-1; otherwise 0.
- A word is accepted when in_valid && in_ready is true at a rising edge.
- IDLE:
  - On accept: shreg <= in_data, cnt <= 0, go to SHIFT.
  - x_valid <= 0, frame_start <= 0, frame_end <= 0; x holds its last value.
- SHIFT with en=1:
  - x <= current head bit: shreg[W-1] if MSB_FIRST, else shreg[0].
  - x_valid <= 1.
  - frame_start <= (cnt==0); frame_end <= (cnt==W-1).
  - Shift shreg toward the head and increment cnt.
- SHIFT with en=1 and cnt==W-1:
  - If in_valid: accept, reload shreg, cnt <= 0, stay in SHIFT. This gives zero gap between frames.
  - Otherwise go to IDLE.
- SHIFT with en=0: x_valid, frame_start and frame_end <= 0; x, shreg and cnt hold. No word is accepted.
- Latency:
  - Accept at edge E0; the first bit appears on x after the first later edge with en=1.
  - With en tied high, the first bit is valid in cycle E0+2.
  - Exactly W x_valid pulses per word.
- Simultaneous in_valid and last-bit emission: both the last bit and the new word's load happen at the same edge.
- in_data is sampled only on accept; later changes have no effect on the frame in flight.
- rst mid-frame: the frame is discarded, no partial replay, and all outputs return to reset values immediately.
- in_valid may be held high with no acceptance; the feeder never drops or duplicates a word.

Decomposition:
- Shared package: FSM state encoding (IDLE=1'b0, SHIFT=1'b1) and a clog2 helper constant function for the counter width.
- Single module, no sub-module needed.
- A testbench wrapper instantiates the feeder chained to the existing Mealy detector.

Test Plan:
- Reset check: assert rst for 3 cycles -> x=0, x_valid=0, frame_start=0, frame_end=0, in_ready=1.
- Single word, W=8, MSB_FIRST=1, en=1, in_data=8'hA5 accepted in cycle N:
  - x_valid is high for cycles N+2..N+9 with x = 1,0,1,0,0,1,0,1.
  - frame_start is high at N+2 and frame_end is high at N+9.
  - in_ready=0 during N+1..N+7 and returns to 1 at N+8.
- Back-to-back: 8'h01 then 8'h80 with in_valid held high:
  - 16 consecutive x_valid cycles, bit stream 00000001_10000000.
  - The second word's frame_start follows the first word's frame_end directly.
- Stall: en pattern 1,0,0,1,... on 8'hC3:
  - x_valid pulses only after en=1 cycles, and exactly 8 of them.
  - The bit order is unchanged: 1,1,0,0,0,0,1,1.
- LSB-first: MSB_FIRST=0, in_data=8'h01 -> x sequence 1,0,0,0,0,0,0,0.
- Reset mid-frame, then chained detector:
  - Assert rst after 3 bits of 8'hFF -> x_valid drops immediately and no further bits appear.
  - Then feed 8'h55 into the detector -> detector y pulses 4 times, on each 0->1 transition.
